// File: rtl/sync_evt_pkg.sv
// sync_evt_pkg: shared types and width helpers for the synchronized event filter.
// Related build option: SYNC_EVT_ANY_EDGE_EN (see sync_evt_filter).
package sync_evt_pkg;

    // Qualification FSM encoding; values are fixed so state dumps read consistently.
    typedef enum logic [1:0] {
        STABLE_LO = 2'd0,
        QUAL_HI   = 2'd1,
        STABLE_HI = 2'd2,
        QUAL_LO   = 2'd3
    } qual_state_e;

    // Number of bits needed to hold values 0..max_val (at least one bit).
    function automatic int bits_for(input int max_val);
        int w;
        w = 32'sd1;
        for (int i = 32'sd1; i < 32'sd31; i++) begin
            if ((32'sd1 << i) <= max_val) begin
                w = i + 32'sd1;
            end else begin
                w = w;
            end
        end
        return w;
    endfunction

    // Width of the pending-event counter for a given saturation value.
    function automatic int cnt_width(input int pend_max);
        return bits_for(pend_max);
    endfunction

    // Width of the qualification counter for a given filter length.
    function automatic int qcnt_width(input int filt_cycles);
        return bits_for(filt_cycles);
    endfunction

endpackage

// File: rtl/sync_evt_filter_qual.sv
// sync_evt_qual: stability filter for a synchronized level. A new level must be
// seen FILT_CYCLES consecutive enabled cycles before it is accepted; acceptance
// updates filt_q and fires a one-cycle rise/fall pulse.
module sync_evt_qual
    import sync_evt_pkg::*;
#(
    parameter int FILT_CYCLES = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic din,
    input  logic en,
    output logic filt_q,
    output logic rise_p,
    output logic fall_p
);

    localparam int QW = qcnt_width(FILT_CYCLES);
    // Count value seen on the cycle whose next edge completes qualification.
    localparam logic [QW-1:0] QLAST = QW'(FILT_CYCLES - 1);
    localparam logic [QW-1:0] QONE  = QW'(32'd1);
    localparam logic [QW-1:0] QZERO = QW'(32'd0);

    qual_state_e     state_r, state_s;
    logic [QW-1:0]   qcnt_r, qcnt_s;
    logic            filt_r, filt_s;
    logic            rise_r, rise_s;
    logic            fall_r, fall_s;

    // Next-state and pulse decode; a single-cycle filter skips the QUAL states.
    always_comb begin
        state_s = state_r;
        qcnt_s  = qcnt_r;
        filt_s  = filt_r;
        rise_s  = 1'b0;
        fall_s  = 1'b0;
        case (state_r)
            STABLE_LO: begin
                if (din && en) begin
                    if (FILT_CYCLES == 1) begin
                        state_s = STABLE_HI;
                        qcnt_s  = QZERO;
                        filt_s  = 1'b1;
                        rise_s  = 1'b1;
                    end else begin
                        state_s = QUAL_HI;
                        qcnt_s  = QONE;
                    end
                end else begin
                    state_s = STABLE_LO;
                end
            end
            QUAL_HI: begin
                if (!en || !din) begin
                    state_s = STABLE_LO;
                    qcnt_s  = QZERO;
                end else if (qcnt_r == QLAST) begin
                    state_s = STABLE_HI;
                    qcnt_s  = QZERO;
                    filt_s  = 1'b1;
                    rise_s  = 1'b1;
                end else begin
                    qcnt_s  = qcnt_r + QONE;
                end
            end
            STABLE_HI: begin
                if (!din && en) begin
                    if (FILT_CYCLES == 1) begin
                        state_s = STABLE_LO;
                        qcnt_s  = QZERO;
                        filt_s  = 1'b0;
                        fall_s  = 1'b1;
                    end else begin
                        state_s = QUAL_LO;
                        qcnt_s  = QONE;
                    end
                end else begin
                    state_s = STABLE_HI;
                end
            end
            QUAL_LO: begin
                if (!en || din) begin
                    state_s = STABLE_HI;
                    qcnt_s  = QZERO;
                end else if (qcnt_r == QLAST) begin
                    state_s = STABLE_LO;
                    qcnt_s  = QZERO;
                    filt_s  = 1'b0;
                    fall_s  = 1'b1;
                end else begin
                    qcnt_s  = qcnt_r + QONE;
                end
            end
            default: begin
                state_s = STABLE_LO;
                qcnt_s  = QZERO;
                filt_s  = 1'b0;
            end
        endcase
    end

    // State, counter and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= STABLE_LO;
            qcnt_r  <= QZERO;
            filt_r  <= 1'b0;
            rise_r  <= 1'b0;
            fall_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            qcnt_r  <= qcnt_s;
            filt_r  <= filt_s;
            rise_r  <= rise_s;
            fall_r  <= fall_s;
        end
    end

    assign filt_q = filt_r;
    assign rise_p = rise_r;
    assign fall_p = fall_r;

endmodule

// File: rtl/sync_evt_filter.sv
// sync_evt_filter: glitch filter plus saturating pending-event queue with a
// req/ack handshake and a sticky overflow flag.
// Build option: define SYNC_EVT_ANY_EDGE_EN to queue falling edges as well as rising.
module sync_evt_filter
    import sync_evt_pkg::*;
#(
    parameter  int FILT_CYCLES = 4,
    parameter  int PEND_MAX    = 15,
    localparam int CNT_W       = cnt_width(PEND_MAX)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             din,
    input  logic             en,
    output logic             filt_q,
    output logic             rise_p,
    output logic             fall_p,
    output logic             evt_req,
    input  logic             evt_ack,
    output logic [CNT_W-1:0] evt_cnt,
    output logic             ovf,
    input  logic             ovf_clr
);

    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(PEND_MAX);
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(32'd0);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(32'd1);

    logic             rise_s;
    logic             fall_s;
    logic             inc_s;
    logic             dec_s;
    logic             ovf_set_s;
    logic [CNT_W-1:0] cnt_r, cnt_s;
    logic             ovf_r, ovf_s;

    sync_evt_qual #(
        .FILT_CYCLES (FILT_CYCLES)
    ) u_qual (
        .clk    (clk),
        .reset  (reset),
        .din    (din),
        .en     (en),
        .filt_q (filt_q),
        .rise_p (rise_s),
        .fall_p (fall_s)
    );

`ifdef SYNC_EVT_ANY_EDGE_EN
    assign inc_s = rise_s | fall_s;
`else
    assign inc_s = rise_s;
`endif

    // An ack against an empty queue is ignored.
    assign dec_s     = evt_ack & (cnt_r != CNT_ZERO);
    assign ovf_set_s = inc_s & ~dec_s & (cnt_r == CNT_MAX);

    // Pending-count update and sticky overflow; a new overflow beats ovf_clr.
    always_comb begin
        cnt_s = cnt_r;
        ovf_s = ovf_r;
        case ({inc_s, dec_s})
            2'b10: begin
                if (cnt_r == CNT_MAX) begin
                    cnt_s = cnt_r;
                end else begin
                    cnt_s = cnt_r + CNT_ONE;
                end
            end
            2'b01:   cnt_s = cnt_r - CNT_ONE;
            default: cnt_s = cnt_r;
        endcase
        if (ovf_set_s) begin
            ovf_s = 1'b1;
        end else if (ovf_clr) begin
            ovf_s = 1'b0;
        end else begin
            ovf_s = ovf_r;
        end
    end

    // Pending counter and overflow registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_r <= CNT_ZERO;
            ovf_r <= 1'b0;
        end else begin
            cnt_r <= cnt_s;
            ovf_r <= ovf_s;
        end
    end

    assign rise_p  = rise_s;
    assign fall_p  = fall_s;
    assign evt_cnt = cnt_r;
    assign evt_req = (cnt_r != CNT_ZERO);
    assign ovf     = ovf_r;

endmodule
